axi_lite_ram: RTL and testbench

AXI_LITE_RAM -- requirements
Module: axi_lite_ram

---
 rtl/axi_lite_ram.sv | 258 +++++++++++++++++++++++++
 tb/tb_axi_lite_ram.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_ram.sv
// ============================================================================
// axi_lite_ram -- AXI4-Lite slave backed by a word-addressed 32-bit RAM.
//
// Read and write channels run independently, so a read and a write can both
// complete in the same cycle. The word index is addr[ADDR_BITS-1:2]. Bits
// addr[1:0] are ignored.
//
// Write path: W_COLLECT accepts AW and W in any order, or in the same cycle.
// The cycle after both are held, the strobed bytes are written and B is
// raised (W_RESP). A write is completed every 3 cycles at best.
// Read path: R_IDLE samples the array on the AR handshake. R_RESP presents
// that word one cycle later and holds it until R is accepted. A read is
// completed every 2 cycles at best.
//
// Optional feature (macro AXI_LITE_RAM_RANGE_CHECK_EN):
//   defined   - addresses outside [BASE_ADDR, BASE_ADDR + 2**ADDR_BITS) get
//               SLVERR. Such writes are dropped and such reads return 0.
//   undefined - address bits at and above ADDR_BITS are ignored (the RAM
//               aliases), and every response is OKAY.
//
// Parameters:
//   ADDR_BITS  byte-address width of the RAM (depth = 2**(ADDR_BITS-2) words)
//   BASE_ADDR  byte address of word 0, aligned to 2**ADDR_BITS
//
// Ports:
//   clk, rstn                         clock, synchronous active-low reset
//   axi_ar* / axi_r*                  AXI4-Lite read address / read data
//   axi_aw* / axi_w* / axi_b*         AXI4-Lite write address / data / resp
//   axi_arprot, axi_awprot            accepted but ignored
// ============================================================================
module axi_lite_ram #(
    parameter int unsigned ADDR_BITS = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    // read address / data
    input  logic [31:0] axi_araddr,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    input  logic [2:0]  axi_arprot,
    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp,
    output logic        axi_rvalid,
    input  logic        axi_rready,
    // write address / data / response
    input  logic [31:0] axi_awaddr,
    input  logic        axi_awvalid,
    output logic        axi_awready,
    input  logic [2:0]  axi_awprot,
    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,
    input  logic        axi_wvalid,
    output logic        axi_wready,
    output logic [1:0]  axi_bresp,
    output logic        axi_bvalid,
    input  logic        axi_bready
);

    localparam int unsigned IDX_BITS = ADDR_BITS - 2;
    localparam int unsigned DEPTH    = 1 << IDX_BITS;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic { W_COLLECT, W_RESP } w_state_e;
    typedef enum logic { R_IDLE,    R_RESP } r_state_e;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [31:0] mem_q [DEPTH];

    // ------------------------------------------------------------------
    // Write channel state
    // ------------------------------------------------------------------
    w_state_e              w_state_q;
    logic                  awready_q;
    logic                  wready_q;
    logic                  aw_held_q;
    logic                  w_held_q;
    logic                  aw_ok_q;
    logic [IDX_BITS-1:0]   aw_idx_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;

    // ------------------------------------------------------------------
    // Read channel state
    // ------------------------------------------------------------------
    r_state_e              r_state_q;
    logic                  arready_q;
    logic                  rvalid_q;
    logic [31:0]           rdata_q;
    logic [1:0]            rresp_q;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                  aw_ok_d;
    logic                  ar_ok_d;
    logic                  commit_d;
    logic                  mem_we_d;
    logic [IDX_BITS-1:0]   ar_idx_d;
    logic [31:0]           rdata_d;

`ifdef AXI_LITE_RAM_RANGE_CHECK_EN
    // BASE_ADDR is aligned to the window, so a match on the upper bits is
    // the same as a full range compare.
    assign aw_ok_d = (axi_awaddr[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS]);
    assign ar_ok_d = (axi_araddr[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS]);
`else
    assign aw_ok_d = 1'b1;
    assign ar_ok_d = 1'b1;
`endif

    // Both halves of the write are held. The write commits on this edge.
    assign commit_d = (w_state_q == W_COLLECT) && aw_held_q && w_held_q;
    // A write that is held when reset is asserted is discarded.
    assign mem_we_d = rstn && commit_d && aw_ok_q;
    assign ar_idx_d = axi_araddr[ADDR_BITS-1:2];

    // NOTE: an always_comb assigns every output a default first, so a path
    // that skips an assignment cannot infer a latch.
    always_comb begin
        rdata_d = 32'h0;
        if (ar_ok_d) begin
            rdata_d = mem_q[ar_idx_d];
        end
    end

    // Address bits this configuration does not decode, and the prot inputs.
    logic unused_ok;
    assign unused_ok = ^{axi_arprot, axi_awprot, axi_araddr[1:0], axi_awaddr[1:0],
                         axi_araddr[31:ADDR_BITS], axi_awaddr[31:ADDR_BITS], BASE_ADDR};

    // ------------------------------------------------------------------
    // RAM array. It is written on the commit edge. A read sampling the same
    // word on that edge sees the old contents.
    // ------------------------------------------------------------------
    // NOTE: the array is deliberately not reset. The contents survive rstn,
    // and the array can map onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we_d) begin
            if (wstrb_q[0]) mem_q[aw_idx_q][7:0]   <= wdata_q[7:0];
            if (wstrb_q[1]) mem_q[aw_idx_q][15:8]  <= wdata_q[15:8];
            if (wstrb_q[2]) mem_q[aw_idx_q][23:16] <= wdata_q[23:16];
            if (wstrb_q[3]) mem_q[aw_idx_q][31:24] <= wdata_q[31:24];
        end
    end

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------
    // NOTE: all sequential state uses non-blocking assignments. Every
    // register then updates from pre-edge values, and simulation matches
    // the hardware.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            w_state_q <= W_COLLECT;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            case (w_state_q)
                W_COLLECT: begin
                    if (aw_held_q && w_held_q) begin
                        bvalid_q  <= 1'b1;
                        bresp_q   <= aw_ok_q ? RESP_OKAY : RESP_SLVERR;
                        aw_held_q <= 1'b0;
                        w_held_q  <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        w_state_q <= W_RESP;
                    end else begin
                        // Each ready drops as soon as its half is captured.
                        // A ready that is low coming out of reset rises here.
                        if (axi_awvalid && awready_q) begin
                            aw_held_q <= 1'b1;
                            aw_ok_q   <= aw_ok_d;
                            aw_idx_q  <= axi_awaddr[ADDR_BITS-1:2];
                            awready_q <= 1'b0;
                        end else begin
                            awready_q <= !aw_held_q;
                        end
                        if (axi_wvalid && wready_q) begin
                            w_held_q <= 1'b1;
                            wdata_q  <= axi_wdata;
                            wstrb_q  <= axi_wstrb;
                            wready_q <= 1'b0;
                        end else begin
                            wready_q <= !w_held_q;
                        end
                    end
                end
                W_RESP: begin
                    if (axi_bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        w_state_q <= W_COLLECT;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'h0;
            rresp_q   <= RESP_OKAY;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (axi_arvalid && arready_q) begin
                        rdata_q   <= rdata_d;
                        rresp_q   <= ar_ok_d ? RESP_OKAY : RESP_SLVERR;
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        r_state_q <= R_RESP;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_RESP: begin
                    if (axi_rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        r_state_q <= R_IDLE;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign axi_awready = awready_q;
    assign axi_wready  = wready_q;
    assign axi_bvalid  = bvalid_q;
    assign axi_bresp   = bresp_q;
    assign axi_arready = arready_q;
    assign axi_rvalid  = rvalid_q;
    assign axi_rdata   = rdata_q;
    assign axi_rresp   = rresp_q;

endmodule

// File: tb/tb_axi_lite_ram.sv
// ============================================================================
// tb_axi_lite_ram -- self-checking bench for axi_lite_ram.
//
// The reference model is a plain word array updated with byte-merge
// arithmetic. It decides each expected read word and each response code.
// Inputs are driven and outputs sampled on the falling clock edge.
// ============================================================================
module tb_axi_lite_ram;

    localparam int unsigned ADDR_BITS = 12;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
    localparam int unsigned WINDOW    = 1 << ADDR_BITS;
    localparam int          TMO       = 50;

    logic        clk;
    logic        rstn;
    logic [31:0] axi_araddr;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [2:0]  axi_arprot;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic        axi_rready;
    logic [31:0] axi_awaddr;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [2:0]  axi_awprot;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;

    axi_lite_ram #(
        .ADDR_BITS (ADDR_BITS),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .axi_araddr  (axi_araddr),
        .axi_arvalid (axi_arvalid),
        .axi_arready (axi_arready),
        .axi_arprot  (axi_arprot),
        .axi_rdata   (axi_rdata),
        .axi_rresp   (axi_rresp),
        .axi_rvalid  (axi_rvalid),
        .axi_rready  (axi_rready),
        .axi_awaddr  (axi_awaddr),
        .axi_awvalid (axi_awvalid),
        .axi_awready (axi_awready),
        .axi_awprot  (axi_awprot),
        .axi_wdata   (axi_wdata),
        .axi_wstrb   (axi_wstrb),
        .axi_wvalid  (axi_wvalid),
        .axi_wready  (axi_wready),
        .axi_bresp   (axi_bresp),
        .axi_bvalid  (axi_bvalid),
        .axi_bready  (axi_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a flat word array seen through the address window
    // ------------------------------------------------------------------
    logic [31:0] ref_mem [WINDOW/4];

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE_ADDR) % WINDOW) / 4;
    endfunction

    function automatic bit in_window(input logic [31:0] a);
`ifdef AXI_LITE_RAM_RANGE_CHECK_EN
        return (a >= BASE_ADDR) && (a - BASE_ADDR < WINDOW);
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s, output logic [1:0] resp);
        int i;
        if (!in_window(a)) begin
            resp = 2'b10;
            return;
        end
        resp = 2'b00;
        i = widx(a);
        for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[i][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic model_read(input logic [31:0] a, output logic [31:0] d,
                              output logic [1:0] resp);
        if (!in_window(a)) begin
            d    = 32'h0;
            resp = 2'b10;
        end else begin
            d    = ref_mem[widx(a)];
            resp = 2'b00;
        end
    endtask

    // ------------------------------------------------------------------
    // Channel helpers. Each is entered and left on a falling edge.
    // ------------------------------------------------------------------
    task automatic finish_b(input string tag, input logic [1:0] exp_resp, input int b_dly);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < TMO; n++) begin
            if (axi_bvalid) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        check({tag, "_bvalid_timeout"}, seen, 1);
        for (int i = 0; i < b_dly; i++) begin
            check({tag, "_bvalid_hold"}, axi_bvalid, 1);
            check({tag, "_awready_in_resp"}, axi_awready, 0);
            check({tag, "_wready_in_resp"}, axi_wready, 0);
            @(negedge clk);
        end
        check({tag, "_bresp"}, axi_bresp, exp_resp);
        axi_bready = 1'b1;
        @(negedge clk);
        axi_bready = 1'b0;
        check({tag, "_bvalid_clr"}, axi_bvalid, 0);
        check({tag, "_awready_back"}, axi_awready, 1);
        check({tag, "_wready_back"}, axi_wready, 1);
    endtask

    task automatic axi_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             input int b_dly);
        logic [1:0] exp_resp;
        bit aw_seen;
        bit w_seen;
        model_write(addr, data, strb, exp_resp);
        aw_seen = 1'b0;
        w_seen  = 1'b0;
        fork
            begin
                repeat (aw_dly) @(negedge clk);
                axi_awaddr  = addr;
                axi_awvalid = 1'b1;
                for (int n = 0; n < TMO; n++) begin
                    if (axi_awready) begin aw_seen = 1'b1; break; end
                    @(negedge clk);
                end
                @(negedge clk);
                axi_awvalid = 1'b0;
            end
            begin
                repeat (w_dly) @(negedge clk);
                axi_wdata  = data;
                axi_wstrb  = strb;
                axi_wvalid = 1'b1;
                for (int n = 0; n < TMO; n++) begin
                    if (axi_wready) begin w_seen = 1'b1; break; end
                    @(negedge clk);
                end
                @(negedge clk);
                axi_wvalid = 1'b0;
            end
        join
        check({tag, "_aw_handshake"}, aw_seen, 1);
        check({tag, "_w_handshake"}, w_seen, 1);
        finish_b(tag, exp_resp, b_dly);
    endtask

    task automatic axi_read(input string tag, input logic [31:0] addr, input int ar_dly,
                            input int r_dly);
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        bit seen;
        model_read(addr, exp_data, exp_resp);
        seen = 1'b0;
        repeat (ar_dly) @(negedge clk);
        axi_araddr  = addr;
        axi_arvalid = 1'b1;
        for (int n = 0; n < TMO; n++) begin
            if (axi_arready) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        check({tag, "_ar_handshake"}, seen, 1);
        check({tag, "_rvalid_early"}, axi_rvalid, 0);
        @(negedge clk);
        axi_arvalid = 1'b0;
        // Data must be valid exactly one cycle after the AR handshake.
        check({tag, "_rvalid_latency"}, axi_rvalid, 1);
        check({tag, "_rdata"}, axi_rdata, exp_data);
        check({tag, "_rresp"}, axi_rresp, exp_resp);
        for (int i = 0; i < r_dly; i++) begin
            @(negedge clk);
            check({tag, "_rvalid_hold"}, axi_rvalid, 1);
            check({tag, "_rdata_hold"}, axi_rdata, exp_data);
            check({tag, "_arready_in_resp"}, axi_arready, 0);
        end
        axi_rready = 1'b1;
        @(negedge clk);
        axi_rready = 1'b0;
        check({tag, "_rvalid_clr"}, axi_rvalid, 0);
        check({tag, "_arready_back"}, axi_arready, 1);
    endtask

    // Reset state of every output.
    task automatic check_reset_outputs(input string tag);
        check({tag, "_arready"}, axi_arready, 0);
        check({tag, "_awready"}, axi_awready, 0);
        check({tag, "_wready"},  axi_wready,  0);
        check({tag, "_rvalid"},  axi_rvalid,  0);
        check({tag, "_bvalid"},  axi_bvalid,  0);
        check({tag, "_rdata"},   axi_rdata,   32'h0);
        check({tag, "_rresp"},   axi_rresp,   2'b00);
        check({tag, "_bresp"},   axi_bresp,   2'b00);
    endtask

    task automatic check_idle_readys(input string tag);
        check({tag, "_arready"}, axi_arready, 1);
        check({tag, "_awready"}, axi_awready, 1);
        check({tag, "_wready"},  axi_wready,  1);
        check({tag, "_rvalid"},  axi_rvalid,  0);
        check({tag, "_bvalid"},  axi_bvalid,  0);
    endtask

    // Hard stop in case a stimulus path hangs in a way the bounded waits
    // above do not cover.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old_val;
        logic [31:0] wa;
        logic [31:0] ra;
        logic [1:0]  resp;
        int          wi;
        int          ri;
        int          hs_cyc [4];
        int          cnt;

        rstn        = 1'b0;
        axi_araddr  = '0;
        axi_arvalid = 1'b0;
        axi_arprot  = '0;
        axi_rready  = 1'b0;
        axi_awaddr  = '0;
        axi_awvalid = 1'b0;
        axi_awprot  = '0;
        axi_wdata   = '0;
        axi_wstrb   = '0;
        axi_wvalid  = 1'b0;
        axi_bready  = 1'b0;

        // -------- reset state and release --------
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rstn = 1'b1;
        @(negedge clk);
        check_idle_readys("post_reset");

        // -------- fill a region so every later read has a known value --------
        for (int w = 0; w < 64; w++)
            axi_write("init", 32'(w * 4), $urandom, 4'hF, 0, 0, 0);
        for (int w = 0; w < 64; w += 9)
            axi_read("init_rd", 32'(w * 4), 0, 0);

        // -------- full-word write and read-back --------
        axi_write("dead", 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
        axi_read("dead", 32'h10, 0, 0);

        // -------- byte strobes, with a byte offset in the address --------
        axi_write("strb_base", 32'h20, 32'h1122_3344, 4'hF, 0, 0, 0);
        axi_write("strb_0101", 32'h22, 32'hAABB_CCDD, 4'b0101, 0, 0, 0);
        axi_read("strb_0101", 32'h20, 0, 0);
        axi_write("strb_none", 32'h20, 32'hFFFF_FFFF, 4'b0000, 0, 0, 0);
        axi_read("strb_none", 32'h20, 0, 0);

        // -------- W two cycles before AW, B held back 5 cycles --------
        axi_write("w_first", 32'h28, 32'h0BAD_F00D, 4'hF, 2, 0, 5);
        axi_write("aw_first", 32'h2C, 32'h1234_5678, 4'hF, 0, 3, 2);
        axi_read("w_first", 32'h28, 1, 3);
        axi_read("aw_first", 32'h2C, 0, 1);

        // -------- read on the same edge the write commits --------
        axi_write("coll_init", 32'h30, 32'h1, 4'hF, 0, 0, 0);
        old_val     = ref_mem[widx(32'h30)];
        axi_awaddr  = 32'h30;
        axi_wdata   = 32'h2;
        axi_wstrb   = 4'hF;
        axi_awvalid = 1'b1;
        axi_wvalid  = 1'b1;
        @(negedge clk);
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        check("coll_awready_held", axi_awready, 0);
        check("coll_wready_held", axi_wready, 0);
        axi_araddr  = 32'h30;
        axi_arvalid = 1'b1;
        @(negedge clk);
        axi_arvalid = 1'b0;
        check("coll_bvalid", axi_bvalid, 1);
        check("coll_rvalid", axi_rvalid, 1);
        check("coll_rdata_old", axi_rdata, old_val);
        model_write(32'h30, 32'h2, 4'hF, resp);
        check("coll_bresp", axi_bresp, resp);
        axi_bready = 1'b1;
        axi_rready = 1'b1;
        @(negedge clk);
        axi_bready = 1'b0;
        axi_rready = 1'b0;
        axi_read("coll_new", 32'h30, 0, 0);

        // -------- address outside the window: aliasing or SLVERR --------
        axi_write("window_hi", BASE_ADDR + WINDOW, 32'h5A5A_0001, 4'hF, 0, 0, 0);
        axi_read("window_hi", BASE_ADDR + WINDOW, 0, 0);
        axi_read("window_w0", BASE_ADDR, 0, 0);

        // -------- back-to-back writes: one per 3 cycles --------
        model_write(32'h40, 32'hC0DE_0040, 4'hF, resp);
        axi_awaddr  = 32'h40;
        axi_wdata   = 32'hC0DE_0040;
        axi_wstrb   = 4'hF;
        axi_awvalid = 1'b1;
        axi_wvalid  = 1'b1;
        axi_bready  = 1'b1;
        cnt = 0;
        for (int n = 0; n < TMO && cnt < 4; n++) begin
            if (axi_awready) begin hs_cyc[cnt] = cyc; cnt++; end
            if (axi_bvalid) check("b2b_w_bresp", axi_bresp, resp);
            @(negedge clk);
        end
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        repeat (3) @(negedge clk);
        axi_bready = 1'b0;
        check("b2b_w_count", cnt, 4);
        for (int i = 0; i < 3; i++)
            check("b2b_w_spacing", hs_cyc[i+1] - hs_cyc[i], 3);
        check("b2b_w_bvalid_clr", axi_bvalid, 0);

        // -------- back-to-back reads: one per 2 cycles --------
        model_read(32'h40, old_val, resp);
        axi_araddr  = 32'h40;
        axi_arvalid = 1'b1;
        axi_rready  = 1'b1;
        cnt = 0;
        for (int n = 0; n < TMO && cnt < 4; n++) begin
            if (axi_arready) begin hs_cyc[cnt] = cyc; cnt++; end
            if (axi_rvalid) check("b2b_r_rdata", axi_rdata, old_val);
            @(negedge clk);
        end
        axi_arvalid = 1'b0;
        repeat (2) @(negedge clk);
        axi_rready = 1'b0;
        check("b2b_r_count", cnt, 4);
        for (int i = 0; i < 3; i++)
            check("b2b_r_spacing", hs_cyc[i+1] - hs_cyc[i], 2);
        check("b2b_r_rvalid_clr", axi_rvalid, 0);

        // -------- reset while B and R responses are pending --------
        model_write(32'h18, 32'h600D_0018, 4'hF, resp);
        axi_awaddr  = 32'h18;
        axi_wdata   = 32'h600D_0018;
        axi_wstrb   = 4'hF;
        axi_awvalid = 1'b1;
        axi_wvalid  = 1'b1;
        @(negedge clk);
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        @(negedge clk);
        check("rst_pend_bvalid", axi_bvalid, 1);
        axi_araddr  = 32'h14;
        axi_arvalid = 1'b1;
        @(negedge clk);
        axi_arvalid = 1'b0;
        check("rst_pend_rvalid", axi_rvalid, 1);
        rstn = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        rstn = 1'b1;
        @(negedge clk);
        check_idle_readys("rst_mid_release");
        axi_read("rst_keep18", 32'h18, 0, 0);
        axi_read("rst_keep14", 32'h14, 0, 0);

        // -------- AW captured, then reset: that AW must be forgotten --------
        axi_awaddr  = 32'h1C;
        axi_awvalid = 1'b1;
        @(negedge clk);
        axi_awvalid = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        axi_wdata  = 32'hCAFE_F00D;
        axi_wstrb  = 4'hF;
        axi_wvalid = 1'b1;
        @(negedge clk);
        axi_wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rst_aw_no_commit", axi_bvalid, 0);
            @(negedge clk);
        end
        model_write(32'h24, 32'hCAFE_F00D, 4'hF, resp);
        axi_awaddr  = 32'h24;
        axi_awvalid = 1'b1;
        @(negedge clk);
        axi_awvalid = 1'b0;
        finish_b("rst_aw_late", resp, 0);
        axi_read("rst_aw_old1c", 32'h1C, 0, 0);
        axi_read("rst_aw_new24", 32'h24, 0, 0);

        // -------- randomized concurrent traffic on distinct words --------
        for (int it = 0; it < 150; it++) begin
            wi = $urandom_range(0, 63);
            ri = $urandom_range(0, 62);
            if (ri >= wi) ri++;
            wa = BASE_ADDR + 32'(wi * 4) + 32'($urandom_range(0, 3))
                 + (32'($urandom_range(0, 3)) << ADDR_BITS);
            ra = BASE_ADDR + 32'(ri * 4) + 32'($urandom_range(0, 3))
                 + (32'($urandom_range(0, 3)) << ADDR_BITS);
            fork
                axi_write("rnd_wr", wa, $urandom, 4'($urandom_range(0, 15)),
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
                axi_read("rnd_rd", ra, $urandom_range(0, 3), $urandom_range(0, 3));
            join
        end
        for (int w = 0; w < 64; w += 5)
            axi_read("final_rd", BASE_ADDR + 32'(w * 4), 0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
